// File: rtl/counter_timer_arbiter_pkg.sv
// counter_timer_arbiter_pkg
//   Shared definitions for the counter/timer arbiter slice: FSM state
//   encoding and default widths.
package counter_timer_arbiter_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/counter_timer_arbiter_if.sv
// counter_timer_arbiter_if
//   Bus between the requesters (master side) and the arbiter (slave side).
//   Handshake: req[i] is a level that acts as "valid" and must stay high for
//   the whole interval; grant[i] high means requester i owns the counter;
//   done[i] is a one-cycle pulse closing the interval. Dropping req[i] while
//   granted aborts the interval without a done pulse.
//   Signals:
//     req      requester -> arbiter  per-requester request level
//     req_len  requester -> arbiter  interval length, requester i at [i*CNT_W +: CNT_W]
//     tick_en  requester -> arbiter  count-enable strobe
//     grant    arbiter -> requester  one-hot owner, zero when idle
//     done     arbiter -> requester  end-of-interval pulse to the owner
//     busy     arbiter -> requester  high while running or finishing
//     count    arbiter -> requester  current counter value
interface counter_timer_arbiter_if
   import counter_timer_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int CNT_W = DEF_CNT_W
) ();

   logic [N_REQ-1:0]       req;
   logic [N_REQ*CNT_W-1:0] req_len;
   logic                   tick_en;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic [CNT_W-1:0]       count;

   modport master (
      output req, req_len, tick_en,
      input  grant, done, busy, count
   );

   modport slave (
      input  req, req_len, tick_en,
      output grant, done, busy, count
   );

endinterface

// File: rtl/counter_timer_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches circularly starting at the
//   index just after ptr and returns the first set request.
//   Ports:
//     req      in   N_REQ  request vector
//     ptr      in   IDX_W  index of the last winner
//     winner   out  N_REQ  one-hot winner (zero when no request)
//     win_idx  out  IDX_W  winner index (zero when no request)
//     any      out  1      at least one request present
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] winner,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   always_comb begin
      int  j;
      logic found;
      j       = 0;
      found   = 1'b0;
      winner  = '0;
      win_idx = '0;
      // k runs 1..N_REQ so the current pointer holder is considered last.
      for (int k = 1; k <= N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[IDX_W'(j)]) begin
            found               = 1'b1;
            winner[IDX_W'(j)]   = 1'b1;
            win_idx             = IDX_W'(j);
         end
      end
      any = found;
   end

endmodule

// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter
//   Shares one CNT_W-bit interval counter between N_REQ requesters. The
//   round-robin winner gets the counter for L tick_en strobes (L latched
//   from its req_len slice at grant time), then receives a done pulse.
//   Ports:
//     sysclk     in   system clock, all logic on posedge
//     reset      in   synchronous active-high reset
//     bus        slave side of counter_timer_arbiter_if
//     state_dbg  out  current FSM state
module counter_timer_arbiter
   import counter_timer_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                    sysclk,
   input  logic                    reset,
   counter_timer_arbiter_if.slave  bus,
   output state_t                  state_dbg
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state_q, state_nxt;
   logic [N_REQ-1:0] grant_q, grant_nxt;
   logic [N_REQ-1:0] done_q, done_nxt;
   logic             busy_q, busy_nxt;
   logic [CNT_W-1:0] count_q, count_nxt;
   logic [CNT_W-1:0] len_q, len_nxt;
   logic [IDX_W-1:0] ptr_q, ptr_nxt;

   logic [N_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic [CNT_W-1:0] sel_len;
   logic             owner_req;
   logic             last_tick;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .winner  (pick_onehot),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Length slice of the would-be winner.
   always_comb begin
      sel_len = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) sel_len = bus.req_len[i*CNT_W +: CNT_W];
      end
   end

   assign owner_req = |(bus.req & grant_q);
   assign last_tick = (count_q == (len_q - CNT_W'(1)));

   // State register and registered outputs.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         count_q <= '0;
         len_q   <= '0;
         ptr_q   <= IDX_W'(N_REQ - 1);
      end else begin
         state_q <= state_nxt;
         grant_q <= grant_nxt;
         done_q  <= done_nxt;
         busy_q  <= busy_nxt;
         count_q <= count_nxt;
         len_q   <= len_nxt;
         ptr_q   <= ptr_nxt;
      end
   end

   // Next-state logic. Abort (owner drops req) beats a completing tick.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) state_nxt = (sel_len == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (!owner_req)                 state_nxt = ST_IDLE;
            else if (bus.tick_en && last_tick) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      grant_nxt = grant_q;
      done_nxt  = '0;
      busy_nxt  = busy_q;
      count_nxt = count_q;
      len_nxt   = len_q;
      ptr_nxt   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_onehot;
               len_nxt   = sel_len;
               ptr_nxt   = pick_idx;
               count_nxt = '0;
               busy_nxt  = 1'b1;
               // Zero-length interval goes straight to DONE with its pulse.
               if (sel_len == '0) done_nxt = pick_onehot;
            end else begin
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               count_nxt = '0;
            end
         end
         ST_RUN: begin
            if (!owner_req) begin
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               count_nxt = '0;
            end else if (bus.tick_en) begin
               // Count holds at L-1 on the completing tick.
               if (last_tick) done_nxt  = grant_q;
               else           count_nxt = count_q + CNT_W'(1);
            end
         end
         default: begin
            grant_nxt = '0;
            busy_nxt  = 1'b0;
            count_nxt = '0;
         end
      endcase
   end

   assign bus.grant = grant_q;
   assign bus.done  = done_q;
   assign bus.busy  = busy_q;
   assign bus.count = count_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// tb_counter_timer_arbiter
//   Directed bench for counter_timer_arbiter: a vector table for the
//   single-interval, round-robin and zero-length cases, then hand-written
//   sequences for abort, mid-run reset and a stalled counter.
module tb_counter_timer_arbiter;
   import counter_timer_arbiter_pkg::*;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [15:0] lens;
      logic       tick;
      logic [3:0] g;
      logic [3:0] d;
      logic       b;
      logic [3:0] c;
      state_t     s;
   } vec_t;

   logic   sysclk;
   logic   reset;
   state_t state_dbg;
   int     checks;
   int     errors;
   vec_t   vecs[$];

   counter_timer_arbiter_if #(.N_REQ(4), .CNT_W(4)) bus ();

   counter_timer_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock / reset
   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   // Driver tasks
   task automatic drive(input logic rst, input logic [3:0] req,
                        input logic [15:0] lens, input logic tick);
      reset       = rst;
      bus.req     = req;
      bus.req_len = lens;
      bus.tick_en = tick;
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic add(input logic rst, input logic [3:0] req, input logic [15:0] lens,
                      input logic tick, input logic [3:0] g, input logic [3:0] d,
                      input logic b, input logic [3:0] c, input state_t s);
      vec_t v;
      v.rst = rst; v.req = req; v.lens = lens; v.tick = tick;
      v.g = g; v.d = d; v.b = b; v.c = c; v.s = s;
      vecs.push_back(v);
   endtask

   // Scoreboard comparison of every output against its expected value
   task automatic chk(input string name, input logic [3:0] g, input logic [3:0] d,
                      input logic b, input logic [3:0] c, input state_t s);
      checks++;
      if (bus.grant !== g) begin
         errors++;
         $display("FAIL %s grant: got %b want %b", name, bus.grant, g);
      end
      checks++;
      if (bus.done !== d) begin
         errors++;
         $display("FAIL %s done: got %b want %b", name, bus.done, d);
      end
      checks++;
      if (bus.busy !== b) begin
         errors++;
         $display("FAIL %s busy: got %b want %b", name, bus.busy, b);
      end
      checks++;
      if (bus.count !== c) begin
         errors++;
         $display("FAIL %s count: got %0d want %0d", name, bus.count, c);
      end
      checks++;
      if (state_dbg !== s) begin
         errors++;
         $display("FAIL %s state: got %0d want %0d", name, state_dbg, s);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive(1'b1, 4'b0000, 16'h0000, 1'b0);
      step();
      step();
      chk("reset", 4'b0000, 4'b0000, 1'b0, 4'd0, ST_IDLE);

      // Single requester, L=3, tick every other cycle
      add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1, 4'd1, ST_RUN);
      add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 1, 4'd1, ST_RUN);
      add(0, 4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1, 4'd2, ST_RUN);
      add(0, 4'b0001, 16'h0003, 0, 4'b0001, 4'b0000, 1, 4'd2, ST_RUN);
      add(0, 4'b0001, 16'h0003, 1, 4'b0001, 4'b0001, 1, 4'd2, ST_DONE);
      add(0, 4'b0000, 16'h0003, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b0000, 16'h0003, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(1, 4'b0000, 16'h0000, 0, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      // All four requesting, L=1, continuous ticks: rotation 0,1,2,3,0
      add(0, 4'b1111, 16'h1111, 1, 4'b0001, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b1111, 16'h1111, 1, 4'b0001, 4'b0001, 1, 4'd0, ST_DONE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0010, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b1111, 16'h1111, 1, 4'b0010, 4'b0010, 1, 4'd0, ST_DONE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0100, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b1111, 16'h1111, 1, 4'b0100, 4'b0100, 1, 4'd0, ST_DONE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b1111, 16'h1111, 1, 4'b1000, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b1111, 16'h1111, 1, 4'b1000, 4'b1000, 1, 4'd0, ST_DONE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b1111, 16'h1111, 1, 4'b0001, 4'b0000, 1, 4'd0, ST_RUN);
      add(0, 4'b1111, 16'h1111, 1, 4'b0001, 4'b0001, 1, 4'd0, ST_DONE);
      add(0, 4'b0000, 16'h1111, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      // Zero-length interval on requester 2: straight to DONE
      add(0, 4'b0100, 16'h1011, 1, 4'b0100, 4'b0100, 1, 4'd0, ST_DONE);
      add(0, 4'b0100, 16'h1011, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      add(0, 4'b0000, 16'h1011, 1, 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].req, vecs[i].lens, vecs[i].tick);
         step();
         chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].d, vecs[i].b, vecs[i].c, vecs[i].s);
      end

      // Abort: owner 1 drops req after two ticks of a 5-tick interval
      drive(0, 4'b0010, 16'h0050, 0); step(); chk("abort_grant", 4'b0010, 4'b0000, 1, 4'd0, ST_RUN);
      drive(0, 4'b0010, 16'h0050, 1); step(); chk("abort_t1", 4'b0010, 4'b0000, 1, 4'd1, ST_RUN);
      step(); chk("abort_t2", 4'b0010, 4'b0000, 1, 4'd2, ST_RUN);
      drive(0, 4'b0000, 16'h0050, 1); step(); chk("abort_idle", 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      // Pointer stayed at 1, so requester 2 beats requester 0
      drive(0, 4'b0101, 16'h0100, 0); step(); chk("abort_next", 4'b0100, 4'b0000, 1, 4'd0, ST_RUN);
      // Abort and completing tick together: abort wins, no done
      drive(0, 4'b0000, 16'h0100, 1); step(); chk("abort_vs_tick", 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      step(); chk("abort_quiet", 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);

      // Reset in the middle of a run at count 2
      drive(0, 4'b0001, 16'h0004, 0); step(); chk("rst_grant", 4'b0001, 4'b0000, 1, 4'd0, ST_RUN);
      drive(0, 4'b0001, 16'h0004, 1); step(); chk("rst_t1", 4'b0001, 4'b0000, 1, 4'd1, ST_RUN);
      step(); chk("rst_t2", 4'b0001, 4'b0000, 1, 4'd2, ST_RUN);
      drive(1, 4'b0001, 16'h0004, 1); step(); chk("rst_mid", 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      drive(0, 4'b0011, 16'h0003, 0); step(); chk("rst_regrant", 4'b0001, 4'b0000, 1, 4'd0, ST_RUN);

      // Latched length survives req_len change; counter stalls without ticks
      drive(0, 4'b0011, 16'h0003, 1); step(); chk("stall_t1", 4'b0001, 4'b0000, 1, 4'd1, ST_RUN);
      drive(0, 4'b0011, 16'hFFFF, 0);
      for (int k = 0; k < 10; k++) begin
         step();
         chk($sformatf("stall_hold%0d", k), 4'b0001, 4'b0000, 1, 4'd1, ST_RUN);
      end
      drive(0, 4'b0011, 16'hFFFF, 1); step(); chk("stall_t2", 4'b0001, 4'b0000, 1, 4'd2, ST_RUN);
      step(); chk("stall_done", 4'b0001, 4'b0001, 1, 4'd2, ST_DONE);
      drive(0, 4'b0011, 16'hFFFF, 0); step(); chk("stall_idle", 4'b0000, 4'b0000, 0, 4'd0, ST_IDLE);
      // Owner 0 still requesting, but requester 1 is next in rotation
      step(); chk("rr_advance", 4'b0010, 4'b0000, 1, 4'd0, ST_RUN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
